// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   WORD_W          : width of one instruction word
//   BYTES_PER_WORD  : number of stream bytes that make up one word
//   BYTE_CNT_W      : width of the byte-within-word counter
//   state_t         : loader FSM states
package imem_program_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_program_loader_byte_to_word_packer.sv
// Collects program bytes into big-endian 32-bit instruction words.
// Ports:
//   clk, reset     : clock and asynchronous active-high reset
//   clear          : restarts word assembly at byte 0 (new load)
//   byte_en        : a byte is accepted this cycle
//   in_data        : the accepted byte
//   word           : assembly register; byte k lands in bits [31-8k:24-8k]
//   word_complete  : combinational, the byte accepted this cycle finishes a word
//   word_valid     : registered one-cycle pulse while a finished word is presented
module byte_to_word_packer
    import imem_program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        in_data,
    output logic [WORD_W-1:0] word,
    output logic              word_complete,
    output logic              word_valid
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [BYTE_CNT_W-1:0] byte_cnt;

    assign word_complete = byte_en && (byte_cnt == LAST_BYTE);

    // The word register is written in place, one byte lane per acceptance,
    // so it only changes when a byte is actually taken from the stream.
    // The byte counter wraps naturally after the last byte of a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            byte_cnt   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_complete;
            if (byte_en) begin
                word[WORD_W - 8 - 8 * int'(byte_cnt) +: 8] <= in_data;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a program from a byte stream into instruction memory while holding
// the processor in reset, then releases it.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   start, num_words    : begin a load of num_words words (1..2**ADDR_W)
//   in_valid, in_data   : program byte stream, big-endian within a word
//   in_ready            : loader accepts a byte this cycle
//   im_we/im_addr/im_wdata : instruction-memory write port
//   cpu_hold            : processor held in reset while high
//   busy, done, err     : status flags
//   checksum            : XOR of all words written in the current load
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WORD_W-1:0] checksum
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_cnt_next;
    logic [ADDR_W:0]   num_latched;
    logic              byte_en;
    logic              start_ok;
    logic              start_accept;
    logic              word_complete;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign byte_en       = in_valid && in_ready;
    assign start_ok      = (num_words != '0) && (num_words <= MAX_WORDS);
    assign start_accept  = start && start_ok && ((state == IDLE) || (state == DONE));
    assign word_cnt_next = word_cnt + 1'b1;
    assign im_wdata      = word;

    byte_to_word_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_accept),
        .byte_en       (byte_en),
        .in_data       (in_data),
        .word          (word),
        .word_complete (word_complete),
        .word_valid    (word_valid)
    );

    // All status outputs are registered alongside the state so they always
    // describe the state being entered on each edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            word_cnt    <= '0;
            num_latched <= '0;
            in_ready    <= 1'b0;
            im_we       <= 1'b0;
            im_addr     <= '0;
            cpu_hold    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            checksum    <= '0;
        end else begin
            case (state)
                // A finished load accepts a new start exactly like idle does;
                // an out-of-range count drops back to idle with err latched.
                IDLE, DONE: begin
                    if (start) begin
                        if (start_ok) begin
                            state       <= RECV;
                            word_cnt    <= '0;
                            num_latched <= num_words;
                            checksum    <= '0;
                            err         <= 1'b0;
                            in_ready    <= 1'b1;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            cpu_hold    <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b0;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (word_complete) begin
                        state    <= WRITE;
                        in_ready <= 1'b0;
                        im_we    <= 1'b1;
                        im_addr  <= word_cnt[ADDR_W-1:0];
                    end
                end
                // word_valid is high for the whole single WRITE cycle; the
                // counter is one bit wider than the address so a full-depth
                // load can be recognised without wrapping.
                WRITE: begin
                    im_we    <= 1'b0;
                    word_cnt <= word_cnt_next;
                    if (word_valid) begin
                        checksum <= checksum ^ word;
                    end
                    if (word_cnt_next == num_latched) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= RECV;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader. Two instances are built: the
// default ADDR_W=8 one and an ADDR_W=2 one for the depth boundary; "sel"
// chooses which instance sees start and whose outputs are observed.
module tb_imem_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  num_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        sel;

    logic        b_in_ready, b_im_we, b_cpu_hold, b_busy, b_done, b_err;
    logic [7:0]  b_im_addr;
    logic [31:0] b_im_wdata, b_checksum;
    logic        s_in_ready, s_im_we, s_cpu_hold, s_busy, s_done, s_err;
    logic [1:0]  s_im_addr;
    logic [31:0] s_im_wdata, s_checksum;

    logic        in_ready, im_we, cpu_hold, busy, done, err;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata, checksum;

    imem_program_loader #(.ADDR_W(8)) dut_big (
        .clk       (clk),
        .reset     (reset),
        .start     (start && !sel),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (b_in_ready),
        .im_we     (b_im_we),
        .im_addr   (b_im_addr),
        .im_wdata  (b_im_wdata),
        .cpu_hold  (b_cpu_hold),
        .busy      (b_busy),
        .done      (b_done),
        .err       (b_err),
        .checksum  (b_checksum)
    );

    imem_program_loader #(.ADDR_W(2)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .start     (start && sel),
        .num_words (num_words[2:0]),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (s_in_ready),
        .im_we     (s_im_we),
        .im_addr   (s_im_addr),
        .im_wdata  (s_im_wdata),
        .cpu_hold  (s_cpu_hold),
        .busy      (s_busy),
        .done      (s_done),
        .err       (s_err),
        .checksum  (s_checksum)
    );

    assign in_ready = sel ? s_in_ready : b_in_ready;
    assign im_we    = sel ? s_im_we    : b_im_we;
    assign im_addr  = sel ? {6'd0, s_im_addr} : b_im_addr;
    assign im_wdata = sel ? s_im_wdata : b_im_wdata;
    assign cpu_hold = sel ? s_cpu_hold : b_cpu_hold;
    assign busy     = sel ? s_busy     : b_busy;
    assign done     = sel ? s_done     : b_done;
    assign err      = sel ? s_err      : b_err;
    assign checksum = sel ? s_checksum : b_checksum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit s;
        int n;
        bit exp_err;
        int gap;
    } vec_t;

    int          compared = 0;
    int          failed   = 0;
    logic [31:0] words[$];
    wr_t         seen[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Record every memory write seen on the observed instance.
    always @(negedge clk) begin
        if (!reset && im_we) begin
            seen.push_back('{addr: im_addr, data: im_wdata});
            checkOutput("ready_during_write", {31'd0, in_ready}, 32'd0);
        end
    end

    // Reference rule: a start is accepted iff 1 <= n <= depth of the instance.
    function automatic bit startAccepted(input bit s, input int n);
        int depth;
        depth = s ? 4 : 256;
        return (n >= 1) && (n <= depth);
    endfunction

    task automatic applyStimulus(input int n);
        @(negedge clk);
        num_words = 9'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Present the byte stream of "words" from byte index "skip" with random
    // idle gaps; a byte advances only when the loader is ready for it.
    task automatic feedWords(input int skip, input int gap);
        int idx;
        int guard;
        int nbytes;
        logic [31:0] w;
        bit v;
        idx    = skip;
        guard  = 0;
        nbytes = words.size() * 4;
        while (idx < nbytes && guard < 20000) begin
            v = ($urandom_range(99) >= gap);
            in_valid = v;
            if (v) begin
                w = words[idx / 4];
                in_data = w[31 - 8 * (idx % 4) -: 8];
                if (in_ready) idx++;
            end else begin
                in_data = 8'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (idx < nbytes) checkOutput("feed_timeout", idx, nbytes);
    endtask

    task automatic waitDone();
        int g;
        g = 0;
        while (!done && g < 100) begin
            @(negedge clk);
            g++;
        end
        checkOutput("done_flag", {31'd0, done}, 32'd1);
    endtask

    task automatic checkLoad();
        logic [31:0] x;
        int n;
        x = '0;
        n = words.size();
        checkOutput("write_count", seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++) begin
            checkOutput($sformatf("write_addr[%0d]", i), {24'd0, seen[i].addr}, i);
            checkOutput($sformatf("write_data[%0d]", i), seen[i].data, words[i]);
        end
        foreach (words[i]) x ^= words[i];
        checkOutput("checksum", checksum, x);
        checkOutput("final_addr", {24'd0, im_addr}, n - 1);
        checkOutput("done_busy", {31'd0, busy}, 32'd0);
        checkOutput("done_hold", {31'd0, cpu_hold}, 32'd0);
        checkOutput("done_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic doLoadCase(input bit s, input int n, input bit exp_err, input int gap);
        sel = s;
        seen.delete();
        words.delete();
        if (!exp_err) for (int i = 0; i < n; i++) words.push_back($urandom);
        applyStimulus(n);
        checkOutput($sformatf("start_err n=%0d", n), {31'd0, err}, {31'd0, exp_err});
        if (exp_err) begin
            checkOutput("rej_busy", {31'd0, busy}, 32'd0);
            checkOutput("rej_hold", {31'd0, cpu_hold}, 32'd1);
            checkOutput("rej_done", {31'd0, done}, 32'd0);
            repeat (3) @(negedge clk);
            checkOutput("rej_no_write", seen.size(), 32'd0);
        end else begin
            checkOutput("acc_ready", {31'd0, in_ready}, 32'd1);
            checkOutput("acc_busy", {31'd0, busy}, 32'd1);
            feedWords(0, gap);
            waitDone();
            checkLoad();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[$];
        reset     = 1'b1;
        start     = 1'b0;
        num_words = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        sel       = 1'b0;

        vecs.push_back('{s: 0, n: 0,   exp_err: 1, gap: 0});
        vecs.push_back('{s: 0, n: 1,   exp_err: 0, gap: 0});
        vecs.push_back('{s: 0, n: 3,   exp_err: 0, gap: 50});
        vecs.push_back('{s: 0, n: 257, exp_err: 1, gap: 0});
        vecs.push_back('{s: 0, n: 256, exp_err: 0, gap: 20});
        vecs.push_back('{s: 0, n: 511, exp_err: 1, gap: 0});
        vecs.push_back('{s: 1, n: 4,   exp_err: 0, gap: 30});
        vecs.push_back('{s: 1, n: 5,   exp_err: 1, gap: 0});
        vecs.push_back('{s: 1, n: 0,   exp_err: 1, gap: 0});
        vecs.push_back('{s: 1, n: 7,   exp_err: 1, gap: 0});
        vecs.push_back('{s: 1, n: 1,   exp_err: 0, gap: 10});

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_im_we", {31'd0, im_we}, 32'd0);
        checkOutput("rst_im_addr", {24'd0, im_addr}, 32'd0);
        checkOutput("rst_im_wdata", im_wdata, 32'd0);
        checkOutput("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("rst_flags", {29'd0, busy, done, err}, 32'd0);
        checkOutput("rst_checksum", checksum, 32'd0);
        reset = 1'b0;

        // Single word, back-to-back bytes: write one cycle after 4th byte.
        $display("[TB] single-word latency");
        seen.delete();
        applyStimulus(1);
        in_valid = 1'b1;
        in_data = 8'h01; @(negedge clk);
        in_data = 8'h0A; @(negedge clk);
        in_data = 8'h48; @(negedge clk);
        in_data = 8'h20; @(negedge clk);
        in_valid = 1'b0;
        checkOutput("lat_we", {31'd0, im_we}, 32'd1);
        checkOutput("lat_addr", {24'd0, im_addr}, 32'd0);
        checkOutput("lat_wdata", im_wdata, 32'h010A4820);
        checkOutput("lat_hold_in_write", {31'd0, cpu_hold}, 32'd1);
        checkOutput("lat_ready_in_write", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("lat_we_off", {31'd0, im_we}, 32'd0);
        checkOutput("lat_done", {31'd0, done}, 32'd1);
        checkOutput("lat_hold_off", {31'd0, cpu_hold}, 32'd0);
        checkOutput("lat_checksum", checksum, 32'h010A4820);
        checkOutput("lat_writes", seen.size(), 32'd1);

        $display("[TB] table vectors");
        foreach (vecs[i]) doLoadCase(vecs[i].s, vecs[i].n, vecs[i].exp_err, vecs[i].gap);

        // Three fixed words with gappy stream.
        $display("[TB] three-word load with gaps");
        sel = 1'b0;
        seen.delete();
        words = '{32'h010A4820, 32'h01286022, 32'h8D0A0000};
        applyStimulus(3);
        feedWords(0, 40);
        waitDone();
        checkLoad();

        // Rejected start, then a valid one clears err.
        $display("[TB] error then recovery");
        doLoadCase(0, 0, 1, 0);
        doLoadCase(0, 1, 0, 0);

        // Reset in the middle of a word: nothing written, clean restart.
        $display("[TB] reset mid-word");
        sel = 1'b0;
        seen.delete();
        applyStimulus(2);
        in_valid = 1'b1;
        in_data = 8'hAB; @(negedge clk);
        in_data = 8'hCD; @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("mid_rst_we", {31'd0, im_we}, 32'd0);
        checkOutput("mid_rst_addr", {24'd0, im_addr}, 32'd0);
        checkOutput("mid_rst_wdata", im_wdata, 32'd0);
        checkOutput("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("mid_rst_flags", {29'd0, busy, done, err}, 32'd0);
        checkOutput("mid_rst_checksum", checksum, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid_rst_no_write", seen.size(), 32'd0);
        doLoadCase(0, 2, 0, 10);

        // Start during RECV is ignored; reload from DONE.
        $display("[TB] start ignored while receiving");
        sel = 1'b0;
        seen.delete();
        words.delete();
        words.push_back($urandom);
        words.push_back($urandom);
        applyStimulus(2);
        in_valid  = 1'b1;
        in_data   = words[0][31:24];
        num_words = 9'd1;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("ign_busy", {31'd0, busy}, 32'd1);
        checkOutput("ign_ready", {31'd0, in_ready}, 32'd1);
        feedWords(1, 20);
        waitDone();
        checkLoad();
        doLoadCase(0, 2, 0, 10);

        $display("[TB] randomized loads");
        for (int k = 0; k < 10; k++) begin
            bit s;
            int n;
            s = 1'($urandom_range(1));
            if (s) n = $urandom_range(7);
            else if ($urandom_range(3) == 0) n = $urandom_range(250, 300);
            else n = $urandom_range(0, 12);
            doLoadCase(s, n, !startAccepted(s, n), $urandom_range(60));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
IMEM_PROGRAM_LOADER -- requirements
Module: imem_program_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width (depth = 2**ADDR_W words).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse; begins a load of num_words words.
REQ-005 num_words  input  ADDR_W+1  word count; sampled only on the cycle start is accepted.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  program byte; big-endian within each 32-bit word.
REQ-008 in_ready  output  1  loader can accept a byte.
REQ-009 im_we  output  1  instruction-memory write strobe.
REQ-010 im_addr  output  ADDR_W  instruction-memory word address.
REQ-011 im_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the processor in reset while high.
REQ-013 busy, done, err  output  1 each  status flags.
REQ-014 checksum  output  32  XOR of all words written in the current load.

Function
REQ-015 FSM states: IDLE, RECV, WRITE, DONE.
REQ-016 IDLE: start with 1 <= num_words <= 2**ADDR_W -> RECV; clear word counter, byte counter, checksum and err; latch num_words.
REQ-017 IDLE: start with num_words = 0 or > 2**ADDR_W -> stay IDLE, err = 1 until next accepted start or reset.
REQ-018 RECV: in_ready = 1; byte accepted when in_valid && in_ready; byte k (0..3) of a word -> bits [31-8k:24-8k].
REQ-019 Acceptance of byte 3 -> WRITE on the next edge; byte counter wraps to 0.
REQ-020 WRITE (exactly one cycle): im_we = 1, in_ready = 0, im_addr = word counter, im_wdata = assembled word; checksum ^= word on that edge.
REQ-021 After WRITE: word counter + 1; if it equals latched num_words -> DONE, else -> RECV.
REQ-022 Latency: im_we asserts the cycle after the 4th byte is accepted; no byte is lost under continuous in_valid.
REQ-023 in_valid low in RECV: hold state; bytes need not be contiguous in time.
REQ-024 busy = 1 in RECV and WRITE; done = 1 only in DONE.
REQ-025 cpu_hold = 1 in IDLE, RECV and WRITE; 0 in DONE.
REQ-026 DONE: valid start -> RECV (cpu_hold returns to 1 on that edge); invalid start -> IDLE with err = 1.
REQ-027 start in RECV or WRITE is ignored.
REQ-028 im_we = 0 and in_ready = 0 outside WRITE and RECV respectively.
REQ-029 im_addr holds its last value outside WRITE; im_wdata updates only on byte acceptance.

Reset
REQ-030 Reset returns the FSM to IDLE from any state, including mid-word and mid-load; the partial word is discarded and is never written.
REQ-031 Reset values: in_ready 0, im_we 0, im_addr 0, im_wdata 0, cpu_hold 1, busy 0, done 0, err 0, checksum 0.

Structure
REQ-032 The shared package holds the FSM state enum, the 32-bit word width, and the byte-per-word constant 4.
REQ-033 One sub-module, byte_to_word_packer, performs byte-counter and big-endian assembly and emits a word_valid pulse.
REQ-034 imem_program_loader holds the FSM, counters, checksum and status flags.

Verification
REQ-035 start, num_words = 1; bytes 01 0A 48 20 back-to-back -> one im_we, im_addr 0, im_wdata 0x010A4820; done = 1; cpu_hold falls 1 cycle after WRITE.
REQ-036 num_words = 3; words 0x010A4820, 0x01286022, 0x8D0A0000; random in_valid gaps -> writes to addresses 0, 1, 2 in order; checksum equals XOR of the three words.
REQ-037 start, num_words = 0 -> err = 1, state stays IDLE, no im_we; then a valid start with num_words = 1 -> err clears.
REQ-038 reset asserted after 2 bytes of word 1 of a 2-word load -> outputs at reset values immediately, no im_we; a fresh load then writes from address 0.
REQ-039 start pulsed during RECV -> ignored, word count unchanged; a start in DONE with num_words = 2 -> reload writes addresses 0, 1.
REQ-040 ADDR_W = 2, num_words = 4 -> im_addr reaches 3 without wrap, done = 1; num_words = 5 -> err = 1.
